// File: rtl/gpr_file_pkg.sv
// Shared definitions for the integer register file: address/data types and constants.
package gpr_file_pkg;

    localparam int unsigned GPR_XLEN   = 32;
    localparam int unsigned GPR_NREG   = 32;
    localparam int unsigned REG_AW     = $clog2(GPR_NREG);

    typedef logic [REG_AW-1:0]   reg_addr_t;
    typedef logic [GPR_XLEN-1:0] reg_word_t;

    localparam logic      ENABLE       = 1'b1;
    localparam logic      DISABLE      = 1'b0;
    localparam reg_word_t ZERO_WORD    = '0;
    localparam reg_addr_t NOP_REG_ADDR = '0;

    // True when an enabled write targets the given read index.
    function automatic logic addr_hit(input logic we, input reg_addr_t waddr, input reg_addr_t raddr);
        return (we == ENABLE) && (waddr == raddr);
    endfunction

endpackage

// File: rtl/gpr_read_port.sv
// One combinational read port with reset, enable, x0 and write-through priority.
module gpr_read_port
    import gpr_file_pkg::*;
#(
    parameter int unsigned XLEN   = GPR_XLEN,
    parameter bit          BYPASS = 1'b1
) (
    input  logic            rst,
    input  logic            re,
    input  reg_addr_t       raddr,
    input  logic            we,
    input  reg_addr_t       waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] rdata
);

    // Priority mux: reset, disabled port and x0 all read zero; bypass beats storage.
    always_comb begin
        rdata = '0;
        if (rst == ENABLE) begin
            rdata = '0;
        end else if (re == DISABLE) begin
            rdata = '0;
        end else if (raddr == NOP_REG_ADDR) begin
            rdata = '0;
        end else if (BYPASS && addr_hit(we, waddr, raddr)) begin
            rdata = wdata;
        end else begin
            rdata = store_data;
        end
    end

endmodule

// File: rtl/gpr_file.sv
// Architectural register file x0..x31: one write port, two combinational read ports.
module gpr_file
    import gpr_file_pkg::*;
#(
    parameter int unsigned XLEN   = GPR_XLEN,
    parameter int unsigned NREG   = GPR_NREG,
    parameter bit          BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  reg_addr_t       waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            re1_i,
    input  reg_addr_t       raddr1_i,
    output logic [XLEN-1:0] rdata1_o,
    input  logic            re2_i,
    input  reg_addr_t       raddr2_i,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] regs [NREG];

    // Storage: synchronous clear on reset; x0 is never written so it stays zero.
    always_ff @(posedge clk) begin
        if (rst == ENABLE) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if ((we_i == ENABLE) && (waddr_i != NOP_REG_ADDR)) begin
            regs[waddr_i] <= wdata_i;
        end
    end

    gpr_read_port #(
        .XLEN       (XLEN),
        .BYPASS     (BYPASS)
    ) u_rport1 (
        .rst        (rst),
        .re         (re1_i),
        .raddr      (raddr1_i),
        .we         (we_i),
        .waddr      (waddr_i),
        .wdata      (wdata_i),
        .store_data (regs[raddr1_i]),
        .rdata      (rdata1_o)
    );

    gpr_read_port #(
        .XLEN       (XLEN),
        .BYPASS     (BYPASS)
    ) u_rport2 (
        .rst        (rst),
        .re         (re2_i),
        .raddr      (raddr2_i),
        .we         (we_i),
        .waddr      (waddr_i),
        .wdata      (wdata_i),
        .store_data (regs[raddr2_i]),
        .rdata      (rdata2_o)
    );

endmodule
